// File: rtl/windowed_regfile.sv
// Register file with overlapping sliding windows over a circular physical array.
// Optional write-to-read forwarding is enabled by defining WRF_BYPASS_EN.
module windowed_regfile #(
  parameter  int DATA_W     = 16,
  parameter  int RA_W       = 2,
  parameter  int PHYS_DEPTH = 8,
  parameter  int WIN_STEP   = 2,
  localparam int NWIN       = PHYS_DEPTH / WIN_STEP,
  localparam int CWP_W      = (NWIN > 1) ? $clog2(NWIN) : 1,
  localparam int DEP_W      = $clog2(NWIN) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RA_W-1:0]   rd_addr1,
  input  logic [RA_W-1:0]   rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [RA_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              call,
  input  logic              ret,
  output logic [CWP_W-1:0]  cwp,
  output logic [DEP_W-1:0]  win_depth,
  output logic              ovf,
  output logic              unf,
  output logic              cmd_err
);

  localparam int PA_W = (PHYS_DEPTH > 1) ? $clog2(PHYS_DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [PHYS_DEPTH];
  logic [DATA_W-1:0] mem_d [PHYS_DEPTH];
  logic [CWP_W-1:0]  cwp_q, cwp_d;
  logic [DEP_W-1:0]  depth_q, depth_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              cmd_err_q, cmd_err_d;
  logic [PA_W-1:0]   rd_idx1, rd_idx2, wr_idx;

  // Window base plus offset is formed at full width before wrapping.
  function automatic logic [PA_W-1:0] phys_idx(input logic [CWP_W-1:0] c,
                                               input logic [RA_W-1:0]  r);
    int full;
    full = int'(c) * WIN_STEP + int'(r);
    return PA_W'(full % PHYS_DEPTH);
  endfunction

  assign rd_idx1 = phys_idx(cwp_q, rd_addr1);
  assign rd_idx2 = phys_idx(cwp_q, rd_addr2);
  assign wr_idx  = phys_idx(cwp_q, wr_addr);

`ifdef WRF_BYPASS_EN
  assign rd_data1 = (wr_en && (wr_idx == rd_idx1)) ? wr_data : mem_q[rd_idx1];
  assign rd_data2 = (wr_en && (wr_idx == rd_idx2)) ? wr_data : mem_q[rd_idx2];
`else
  assign rd_data1 = mem_q[rd_idx1];
  assign rd_data2 = mem_q[rd_idx2];
`endif

  always_comb begin
    for (int i = 0; i < PHYS_DEPTH; i++) mem_d[i] = mem_q[i];
    if (wr_en) mem_d[wr_idx] = wr_data;
  end

  // Window control; conflicting commands take precedence over either move.
  always_comb begin
    cwp_d     = cwp_q;
    depth_d   = depth_q;
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    cmd_err_d = 1'b0;
    if (call && ret) begin
      cmd_err_d = 1'b1;
    end else if (call) begin
      if (depth_q < DEP_W'(NWIN - 1)) begin
        cwp_d   = (cwp_q == CWP_W'(NWIN - 1)) ? '0 : cwp_q + 1'b1;
        depth_d = depth_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (ret) begin
      if (depth_q > DEP_W'(1)) begin
        cwp_d   = (cwp_q == '0) ? CWP_W'(NWIN - 1) : cwp_q - 1'b1;
        depth_d = depth_q - 1'b1;
      end else begin
        unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PHYS_DEPTH; i++) mem_q[i] <= '0;
      cwp_q     <= '0;
      depth_q   <= DEP_W'(1);
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < PHYS_DEPTH; i++) mem_q[i] <= mem_d[i];
      cwp_q     <= cwp_d;
      depth_q   <= depth_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  assign cwp       = cwp_q;
  assign win_depth = depth_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
  assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_windowed_regfile.sv
// Bench for windowed_regfile: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_windowed_regfile;

  localparam int DW    = 16;
  localparam int PHYS  = 8;
  localparam int STEP  = 2;
  localparam int NW    = PHYS / STEP;

  logic        clk;
  logic        rst_n;
  logic [1:0]  rd_addr1, rd_addr2, wr_addr;
  logic [DW-1:0] rd_data1, rd_data2, wr_data;
  logic        wr_en, call, ret;
  logic [1:0]  cwp;
  logic [2:0]  win_depth;
  logic        ovf, unf, cmd_err;

  // Second instance with a wider window so the index wraps across the top.
  logic [2:0]  w_rd_addr1, w_rd_addr2, w_wr_addr;
  logic [DW-1:0] w_rd_data1, w_rd_data2, w_wr_data;
  logic        w_wr_en, w_call, w_ret;
  logic [1:0]  w_cwp;
  logic [2:0]  w_win_depth;
  logic        w_ovf, w_unf, w_cmd_err;

  int total = 0;
  int bad   = 0;
  logic check_en = 1'b0;

  windowed_regfile #(.DATA_W(DW), .RA_W(2), .PHYS_DEPTH(PHYS), .WIN_STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .call(call), .ret(ret),
    .cwp(cwp), .win_depth(win_depth),
    .ovf(ovf), .unf(unf), .cmd_err(cmd_err)
  );

  windowed_regfile #(.DATA_W(DW), .RA_W(3), .PHYS_DEPTH(8), .WIN_STEP(2)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(w_rd_addr1), .rd_addr2(w_rd_addr2),
    .rd_data1(w_rd_data1), .rd_data2(w_rd_data2),
    .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
    .call(w_call), .ret(w_ret),
    .cwp(w_cwp), .win_depth(w_win_depth),
    .ovf(w_ovf), .unf(w_unf), .cmd_err(w_cmd_err)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  int m_mem [PHYS];
  int m_cwp, m_depth;
  int m_ovf, m_unf, m_cmd;

  function automatic int m_phys(input int c, input int r);
    return (c * STEP + r) % PHYS;
  endfunction

  function automatic int m_read(input int r);
    int idx;
    idx = m_phys(m_cwp, r);
`ifdef WRF_BYPASS_EN
    if (wr_en && m_phys(m_cwp, int'(wr_addr)) == idx) return int'(wr_data);
`endif
    return m_mem[idx];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PHYS; i++) m_mem[i] = 0;
      m_cwp = 0; m_depth = 1; m_ovf = 0; m_unf = 0; m_cmd = 0;
    end else begin
      if (wr_en) m_mem[m_phys(m_cwp, int'(wr_addr))] = int'(wr_data);
      m_ovf = 0; m_unf = 0; m_cmd = 0;
      if (call && ret) m_cmd = 1;
      else if (call) begin
        if (m_depth < NW - 1) begin m_cwp = (m_cwp + 1) % NW; m_depth++; end
        else m_ovf = 1;
      end else if (ret) begin
        if (m_depth > 1) begin m_cwp = (m_cwp + NW - 1) % NW; m_depth--; end
        else m_unf = 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("cmp_cwp",   32'(cwp),       32'(m_cwp));
      chk("cmp_depth", 32'(win_depth), 32'(m_depth));
      chk("cmp_ovf",   32'(ovf),       32'(m_ovf));
      chk("cmp_unf",   32'(unf),       32'(m_unf));
      chk("cmp_cmd",   32'(cmd_err),   32'(m_cmd));
      chk("cmp_rd1",   32'(rd_data1),  32'(m_read(int'(rd_addr1))));
      chk("cmp_rd2",   32'(rd_data2),  32'(m_read(int'(rd_addr2))));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic c, input logic r, input logic we,
                     input logic [1:0] wa, input logic [DW-1:0] wd);
    call = c; ret = r; wr_en = we; wr_addr = wa; wr_data = wd;
    @(posedge clk); #1;
    call = 1'b0; ret = 1'b0; wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [DW-1:0] exp);
    rd_addr1 = a; rd_addr2 = a; #1;
    chk({name, "_p1"}, 32'(rd_data1), 32'(exp));
    chk({name, "_p2"}, 32'(rd_data2), 32'(exp));
  endtask

  task automatic win_chk(input string name, input int c, input int d,
                         input logic o, input logic u, input logic e);
    chk({name, "_cwp"},   32'(cwp),       32'(c));
    chk({name, "_depth"}, 32'(win_depth), 32'(d));
    chk({name, "_ovf"},   32'(ovf),       32'(o));
    chk({name, "_unf"},   32'(unf),       32'(u));
    chk({name, "_cmd"},   32'(cmd_err),   32'(e));
  endtask

  task automatic wcyc(input logic c, input logic r, input logic we,
                      input logic [2:0] wa, input logic [DW-1:0] wd);
    w_call = c; w_ret = r; w_wr_en = we; w_wr_addr = wa; w_wr_data = wd;
    @(posedge clk); #1;
    w_call = 1'b0; w_ret = 1'b0; w_wr_en = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b1;
    call = 0; ret = 0; wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr1 = 0; rd_addr2 = 0;
    w_call = 0; w_ret = 0; w_wr_en = 0; w_wr_addr = 0; w_wr_data = 0;
    w_rd_addr1 = 0; w_rd_addr2 = 0;
    #1 rst_n = 1'b0;
    #1 check_en = 1'b1;
    win_chk("reset", 0, 1, 0, 0, 0);
    for (int a = 0; a < 4; a++) rd_chk("reset_rd", 2'(a), 16'h0000);
    @(negedge clk); rst_n = 1'b1;

    // Overlap: caller r3 is callee r1
    cyc(0, 0, 1, 2'd3, 16'hBEEF);
    cyc(1, 0, 0, 2'd0, 16'h0);
    win_chk("overlap", 1, 2, 0, 0, 0);
    rd_chk("overlap_rd", 2'd1, 16'hBEEF);

    // Overflow
    cyc(0, 1, 0, 2'd0, 16'h0);
    cyc(1, 0, 0, 2'd0, 16'h0);
    cyc(1, 0, 0, 2'd0, 16'h0);
    win_chk("ovf_pre", 2, 3, 0, 0, 0);
    cyc(1, 0, 0, 2'd0, 16'h0);
    win_chk("ovf_hit", 2, 3, 1, 0, 0);
    cyc(0, 0, 0, 2'd0, 16'h0);
    win_chk("ovf_clr", 2, 3, 0, 0, 0);

    // Top window, then back down and underflow
    cyc(0, 0, 1, 2'd3, 16'h1234);
    rd_chk("top_r3", 2'd3, 16'h1234);
    rd_chk("top_r1", 2'd1, 16'h0000);
    cyc(0, 1, 0, 2'd0, 16'h0);
    cyc(0, 1, 0, 2'd0, 16'h0);
    win_chk("back0", 0, 1, 0, 0, 0);
    rd_chk("back0_r3", 2'd3, 16'hBEEF);
    cyc(0, 1, 0, 2'd0, 16'h0);
    win_chk("unf_hit", 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 2'd0, 16'h0);
    win_chk("unf_clr", 0, 1, 0, 0, 0);

    // Simultaneous call and ret
    cyc(1, 1, 0, 2'd0, 16'h0);
    win_chk("cmd_hit", 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 2'd0, 16'h0);
    win_chk("cmd_clr", 0, 1, 0, 0, 0);

    // Write with call lands in the old window
    cyc(1, 0, 1, 2'd0, 16'h00AA);
    win_chk("wrcall", 1, 2, 0, 0, 0);
    rd_chk("wrcall_new_r0", 2'd0, 16'h0000);
    rd_chk("wrcall_new_r1", 2'd1, 16'hBEEF);
    cyc(0, 1, 0, 2'd0, 16'h0);
    rd_chk("wrcall_old_r0", 2'd0, 16'h00AA);

    // Same-cycle read of a location being written
    rd_addr1 = 2'd1; rd_addr2 = 2'd0;
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 16'h5A5A;
    #1;
`ifdef WRF_BYPASS_EN
    chk("bypass_rd1", 32'(rd_data1), 32'h5A5A);
`else
    chk("bypass_rd1", 32'(rd_data1), 32'h0000);
`endif
    chk("bypass_rd2", 32'(rd_data2), 32'h00AA);
    @(posedge clk); #1;
    wr_en = 1'b0;
    rd_chk("bypass_after", 2'd1, 16'h5A5A);

    // Wrap-around on the wide-window instance: window 1 r7 is physical 1
    wcyc(1, 0, 0, 3'd0, 16'h0);
    wcyc(0, 0, 1, 3'd7, 16'h1234);
    w_rd_addr1 = 3'd7; #1;
    chk("wrap_w1_r7", 32'(w_rd_data1), 32'h1234);
    wcyc(0, 1, 0, 3'd0, 16'h0);
    w_rd_addr1 = 3'd1; w_rd_addr2 = 3'd7; #1;
    chk("wrap_cwp", 32'(w_cwp), 32'd0);
    chk("wrap_w0_r1", 32'(w_rd_data1), 32'h1234);
    chk("wrap_w0_r7", 32'(w_rd_data2), 32'h0000);

    // Asynchronous reset mid-run
    cyc(1, 0, 0, 2'd0, 16'h0);
    #2 rst_n = 1'b0;
    #1;
    win_chk("midrst", 0, 1, 0, 0, 0);
    for (int a = 0; a < 4; a++) rd_chk("midrst_rd", 2'(a), 16'h0000);
    @(negedge clk); rst_n = 1'b1;
    cyc(1, 0, 1, 2'd2, 16'h7777);
    win_chk("postrst", 1, 2, 0, 0, 0);
    rd_chk("postrst_rd", 2'd0, 16'h7777);

    // Randomized traffic, checked each cycle by the compare process
    for (int n = 0; n < 400; n++) begin
      rd_addr1 = 2'($urandom_range(0, 3));
      rd_addr2 = 2'($urandom_range(0, 3));
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
          16'($urandom_range(0, 65535)));
    end

    @(posedge clk); #1;
    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
